// File: rtl/mem_ctrl_256b.sv
// Multi-cycle controller for the 256-byte RAM: MFA/MFC handshake with programmable
// wait states, SPARC load/store size and sign decode, big-endian byte order, alignment check.
module mem_ctrl_256b #(
    parameter int WAIT_CYCLES = 2,
    parameter int MEM_BYTES   = 256
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        MFA,
    input  logic [5:0]  Opcode,
    input  logic [7:0]  Address,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MFC,
    output logic        MAE,
    output logic        Busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [5:0] OP_LD   = 6'b000000;
    localparam logic [5:0] OP_LDUB = 6'b000001;
    localparam logic [5:0] OP_LDUH = 6'b000010;
    localparam logic [5:0] OP_LDSB = 6'b001001;
    localparam logic [5:0] OP_LDSH = 6'b001010;
    localparam logic [5:0] OP_ST   = 6'b000100;
    localparam logic [5:0] OP_STB  = 6'b000101;
    localparam logic [5:0] OP_STH  = 6'b000110;

    localparam logic       LP_NO_WAIT  = (WAIT_CYCLES == 0);
    localparam logic [3:0] LP_CNT_INIT = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    // Access size in bytes as a code: 0 = no access, 1 = byte, 2 = half, 3 = word
    function automatic logic [1:0] f_size(input logic [5:0] op);
        logic [1:0] sz;
        case (op)
            OP_LD, OP_ST:             sz = 2'd3;
            OP_LDUH, OP_LDSH, OP_STH: sz = 2'd2;
            OP_LDUB, OP_LDSB, OP_STB: sz = 2'd1;
            default:                  sz = 2'd0;
        endcase
        return sz;
    endfunction

    function automatic logic f_is_store(input logic [5:0] op);
        return (op == OP_ST) || (op == OP_STB) || (op == OP_STH);
    endfunction

    function automatic logic f_misaligned(input logic [5:0] op, input logic [7:0] addr);
        logic [1:0] sz;
        sz = f_size(op);
        return ((sz == 2'd2) && addr[0]) || ((sz == 2'd3) && (addr[1:0] != 2'b00));
    endfunction

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [5:0]  r_op;
    logic [7:0]  r_addr;
    logic [31:0] r_din;
    logic [31:0] r_dout;
    logic        r_mfc;
    logic        r_mae;
    logic        r_busy;
    logic [7:0]  r_mem [MEM_BYTES];

    logic [5:0]  w_op;
    logic [7:0]  w_addr;
    logic [31:0] w_din;
    logic [7:0]  w_a1, w_a2, w_a3;
    logic [7:0]  w_b0, w_b1, w_b2, w_b3;
    logic [31:0] w_load_val;
    logic        w_mis;
    logic        w_access;
    logic        w_we;

    // In IDLE the access is driven straight from the inputs; afterwards from the latched copy
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_op   = Opcode;
            w_addr = Address;
            w_din  = DataIn;
        end else begin
            w_op   = r_op;
            w_addr = r_addr;
            w_din  = r_din;
        end
    end

    assign w_a1 = w_addr + 8'd1;
    assign w_a2 = w_addr + 8'd2;
    assign w_a3 = w_addr + 8'd3;
    assign w_b0 = r_mem[w_addr];
    assign w_b1 = r_mem[w_a1];
    assign w_b2 = r_mem[w_a2];
    assign w_b3 = r_mem[w_a3];
    assign w_mis = f_misaligned(Opcode, Address);

    // Big-endian load formatting; non-loads keep the previous DataOut
    always_comb begin
        w_load_val = r_dout;
        case (w_op)
            OP_LD:   w_load_val = {w_b0, w_b1, w_b2, w_b3};
            OP_LDUB: w_load_val = {24'd0, w_b0};
            OP_LDSB: w_load_val = {{24{w_b0[7]}}, w_b0};
            OP_LDUH: w_load_val = {16'd0, w_b0, w_b1};
            OP_LDSH: w_load_val = {{16{w_b0[7]}}, w_b0, w_b1};
            default: w_load_val = r_dout;
        endcase
    end

    assign w_access = ((r_state == ST_IDLE) && MFA && !w_mis && LP_NO_WAIT) ||
                      ((r_state == ST_BUSY) && (r_cnt == 4'd0));
    assign w_we     = w_access && f_is_store(w_op) && !Clr;

    // RAM write port, committed on the edge that enters DONE; not cleared by reset
    always_ff @(posedge Clk) begin
        if (w_we) begin
            case (f_size(w_op))
                2'd1: r_mem[w_addr] <= w_din[7:0];
                2'd2: begin
                    r_mem[w_addr] <= w_din[15:8];
                    r_mem[w_a1]   <= w_din[7:0];
                end
                2'd3: begin
                    r_mem[w_addr] <= w_din[31:24];
                    r_mem[w_a1]   <= w_din[23:16];
                    r_mem[w_a2]   <= w_din[15:8];
                    r_mem[w_a3]   <= w_din[7:0];
                end
                default: ;
            endcase
        end
    end

    // Handshake FSM with registered outputs
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_op    <= 6'd0;
            r_addr  <= 8'd0;
            r_din   <= 32'd0;
            r_dout  <= 32'd0;
            r_mfc   <= 1'b0;
            r_mae   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (MFA) begin
                        r_op   <= Opcode;
                        r_addr <= Address;
                        r_din  <= DataIn;
                        r_busy <= 1'b1;
                        if (w_mis) begin
                            r_state <= ST_DONE;
                            r_mfc   <= 1'b1;
                            r_mae   <= 1'b1;
                        end else if (LP_NO_WAIT) begin
                            r_state <= ST_DONE;
                            r_mfc   <= 1'b1;
                            r_dout  <= w_load_val;
                        end else begin
                            r_state <= ST_BUSY;
                            r_cnt   <= LP_CNT_INIT;
                        end
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_DONE;
                        r_mfc   <= 1'b1;
                        r_dout  <= w_load_val;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    // MFA must drop before a new request is considered
                    if (!MFA) begin
                        r_state <= ST_IDLE;
                        r_mfc   <= 1'b0;
                        r_mae   <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_mfc   <= 1'b0;
                    r_mae   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign DataOut = r_dout;
    assign MFC     = r_mfc;
    assign MAE     = r_mae;
    assign Busy    = r_busy;

endmodule
